pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//   Pipeline hold/flush controller: sole producer of hold_flag consumed by pc_reg, if_id and id_ex.
//   Merges stall requests from ex (multi-cycle ops), clint (interrupt entry) and rib (bus busy).
//   Forwards ex jump requests to pc_reg and sequences a multi-cycle flush (HOLD_ID) after each jump.
//   Watchdog flags holds that persist too long.
// PARAMETERS
//   FLUSH_CYCLES   2    cycles HOLD_ID is asserted per jump, counting the jump cycle (>=1)
//   STALL_TIMEOUT  1024 consecutive held cycles before hold_timeout_o; 0 = watchdog disabled
//   WDT_W          16   watchdog counter width; must satisfy 2^WDT_W-1 >= STALL_TIMEOUT
// PORTS
//   clk                input   1   core clock
//   rst                input   1   asynchronous reset, active-low
//   jump_flag_i        input   1   ex: branch/jump taken this cycle
//   jump_addr_i        input  32   ex: jump target
//   hold_flag_ex_i     input   1   ex: multi-cycle op busy
//   hold_flag_clint_i  input   1   clint: interrupt entry in progress
//   hold_flag_rib_i    input   1   rib: bus granted to another master
//   hold_flag_o        output  3   HOLD_NONE=0, HOLD_PC=1, HOLD_IF=2, HOLD_ID=3
//   jump_flag_o        output  1   to pc_reg: load jump_addr_o
//   jump_addr_o        output 32   to pc_reg: jump target
//   hold_timeout_o     output  1   watchdog expired (sticky until hold released)
// BEHAVIOUR
//   Reset (rst low, async): state=RUN, flush_cnt=0, wdt_cnt=0; outputs forced 0 / HOLD_NONE
//   Requests map: jump->HOLD_ID, ex->HOLD_ID, clint->HOLD_ID, rib->HOLD_PC.
//   hold_flag_o = max(requests this cycle, FSM hold); combinational, zero latency
//   jump_flag_o/jump_addr_o = jump_flag_i/jump_addr_i same cycle; addr 0 when flag low
//   FSM (2 states):
//     RUN:   jump_flag_i & FLUSH_CYCLES>1 -> FLUSH, flush_cnt<=FLUSH_CYCLES-1; FSM hold=NONE
//     FLUSH: FSM hold=HOLD_ID; flush_cnt decrements each cycle; flush_cnt==1 & no jump -> RUN
//            new jump_flag_i in FLUSH: forwarded, flush_cnt reloads to FLUSH_CYCLES-1
//   FLUSH_CYCLES==1: FSM never leaves RUN; HOLD_ID only in the jump cycle
//   Simultaneous jump + rib: HOLD_ID wins (max); jump still forwarded
//   ex/clint/rib holds extend but never shorten a flush; flush_cnt decrements while held
//   Watchdog: wdt_cnt++ (saturating) each cycle hold_flag_o!=HOLD_NONE; cleared the cycle it
//     is NONE; hold_timeout_o=1 while wdt_cnt>=STALL_TIMEOUT and STALL_TIMEOUT!=0
//   Reset mid-flush: immediately RUN, hold released; no residual flush after rst rises
// CONFIGURATION
//   `PIPE_CTRL_PERF_EN defined: adds outputs hold_cycles_o[31:0] (cycles hold_flag_o!=NONE)
//     and jump_cnt_o[31:0] (cycles jump_flag_i=1); both wrap at 2^32, reset to 0
//   undefined: ports and counters absent; all other behaviour identical
// STRUCTURE
//   defines.v: HOLD_NONE/PC/IF/ID, HOLD_FLAG_BUS, PIPE_CTRL_RUN/FLUSH state encodings
//   Sub-module pipe_hold_wdt (counter + compare; params STALL_TIMEOUT, WDT_W)
//   State and counters in gen_dff-style flops with async active-low reset
// TESTING
//   jump_flag_i=1 addr=0x80 one cycle, FLUSH_CYCLES=2 -> jump_flag_o=1 addr=0x80 cycle N;
//     hold_flag_o=3 cycles N,N+1; 0 at N+2
//   hold_flag_rib_i=1 only -> hold_flag_o=1 same cycle; released same cycle as input drops
//   rib=1 and jump=1 same cycle -> hold_flag_o=3, jump_flag_o=1
//   Second jump (addr 0x100) at N+1 during flush -> forwarded; hold=3 through N+2, 0 at N+3
//   STALL_TIMEOUT=8, hold_flag_ex_i held 10 cycles -> hold_timeout_o rises cycle 8, stays
//     through cycle 9; clears the cycle after ex hold drops
//   rst low during FLUSH -> hold_flag_o=0 immediately; after release, no hold; with
//     PIPE_CTRL_PERF_EN, counters read 0

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared hold-level encodings, FSM state codes and helpers for the pipeline hold/flush controller.
package pipe_ctrl_pkg;

   localparam int HOLD_FLAG_BUS = 3;
   typedef logic [HOLD_FLAG_BUS-1:0] hold_t;

   localparam hold_t HOLD_NONE = 3'd0;
   localparam hold_t HOLD_PC   = 3'd1;
   localparam hold_t HOLD_IF   = 3'd2;
   localparam hold_t HOLD_ID   = 3'd3;

   localparam logic [0:0] PIPE_CTRL_RUN   = 1'b0;
   localparam logic [0:0] PIPE_CTRL_FLUSH = 1'b1;

   // Hold levels are ordered, so the strongest request is simply the larger code.
   function automatic hold_t hold_max(input hold_t a, input hold_t b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of stall requests, jump forwarding and hold outputs around pipe_ctrl.
interface pipe_ctrl_if;
   import pipe_ctrl_pkg::*;

   logic        jump_flag_i;
   logic [31:0] jump_addr_i;
   logic        hold_flag_ex_i;
   logic        hold_flag_clint_i;
   logic        hold_flag_rib_i;
   hold_t       hold_flag_o;
   logic        jump_flag_o;
   logic [31:0] jump_addr_o;
   logic        hold_timeout_o;

   modport slave (
      input  jump_flag_i, jump_addr_i, hold_flag_ex_i, hold_flag_clint_i, hold_flag_rib_i,
      output hold_flag_o, jump_flag_o, jump_addr_o, hold_timeout_o
   );

   modport master (
      output jump_flag_i, jump_addr_i, hold_flag_ex_i, hold_flag_clint_i, hold_flag_rib_i,
      input  hold_flag_o, jump_flag_o, jump_addr_o, hold_timeout_o
   );

endinterface

// File: rtl/pipe_hold_wdt.sv
// Hold watchdog: counts consecutive held cycles (saturating) and flags when the run is too long.
module pipe_hold_wdt #(
   parameter int unsigned STALL_TIMEOUT = 1024,
   parameter int          WDT_W         = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic held_i,
   output logic timeout_o
);

   logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      wdt_cnt_d = wdt_cnt_q;
      if (!held_i) begin
         wdt_cnt_d = '0;
      end else if (wdt_cnt_q != '1) begin
         wdt_cnt_d = wdt_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst) wdt_cnt_q <= '0;
      else      wdt_cnt_q <= wdt_cnt_d;
   end

   // The count covers held cycles already completed, so the flag stays up one cycle past release.
   assign timeout_o = (STALL_TIMEOUT != 0) && (32'(wdt_cnt_q) >= STALL_TIMEOUT);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush controller: merges stall requests, forwards jumps, sequences post-jump flush.
// Optional PIPE_CTRL_PERF_EN adds hold_cycles_o / jump_cnt_o performance counters.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES  = 2,
   parameter int unsigned STALL_TIMEOUT = 1024,
   parameter int          WDT_W         = 16
) (
   input  logic        clk,
   input  logic        rst,
   pipe_ctrl_if.slave  bus
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0] hold_cycles_o,
   output logic [31:0] jump_cnt_o
`endif
);

   localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
   localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);

   logic [0:0]      state_q, state_d;
   logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;
   hold_t           fsm_hold, req_hold, hold_raw;
   logic            held;

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      fsm_hold    = HOLD_NONE;
      case (state_q)
         PIPE_CTRL_RUN: begin
            if (bus.jump_flag_i && (FLUSH_CYCLES > 1)) begin
               state_d     = PIPE_CTRL_FLUSH;
               flush_cnt_d = FLUSH_RELOAD;
            end
         end
         PIPE_CTRL_FLUSH: begin
            fsm_hold = HOLD_ID;
            if (bus.jump_flag_i) begin
               flush_cnt_d = FLUSH_RELOAD;
            end else if (flush_cnt_q == FC_W'(1)) begin
               state_d     = PIPE_CTRL_RUN;
               flush_cnt_d = '0;
            end else begin
               flush_cnt_d = flush_cnt_q - 1'b1;
            end
         end
         default: begin
            state_d     = PIPE_CTRL_RUN;
            flush_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      req_hold = HOLD_NONE;
      if (bus.jump_flag_i || bus.hold_flag_ex_i || bus.hold_flag_clint_i) req_hold = HOLD_ID;
      else if (bus.hold_flag_rib_i)                                       req_hold = HOLD_PC;
   end

   assign hold_raw = hold_max(req_hold, fsm_hold);

   // NOTE: outputs are gated by rst so a reset mid-flush releases the pipeline without waiting a clock.
   assign bus.hold_flag_o = rst ? hold_raw : HOLD_NONE;
   assign bus.jump_flag_o = rst & bus.jump_flag_i;
   assign bus.jump_addr_o = bus.jump_flag_o ? bus.jump_addr_i : 32'h0;
   assign held            = (bus.hold_flag_o != HOLD_NONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= PIPE_CTRL_RUN;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   pipe_hold_wdt #(
      .STALL_TIMEOUT (STALL_TIMEOUT),
      .WDT_W         (WDT_W)
   ) u_wdt (
      .clk       (clk),
      .rst       (rst),
      .held_i    (held),
      .timeout_o (bus.hold_timeout_o)
   );

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] hold_cycles_q, jump_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_cycles_q <= '0;
         jump_cnt_q    <= '0;
      end else begin
         hold_cycles_q <= hold_cycles_q + 32'(held);
         jump_cnt_q    <= jump_cnt_q + 32'(bus.jump_flag_i);
      end
   end

   assign hold_cycles_o = hold_cycles_q;
   assign jump_cnt_o    = jump_cnt_q;
`endif

endmodule
